// File: rtl/calib_pkg.sv
// Shared types and helpers for the calibration ID decoder.
//   state_t      - decoder FSM states
//   pix_class_t  - per-pixel colour class
//   COLOR_THRESH_DEFAULT, led_addr_width(), classify()
package calib_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_VALID,
    ST_SETTLE,
    ST_CAPTURE,
    ST_DRAIN,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    CLS_RED,
    CLS_BLUE,
    CLS_NONE
  } pix_class_t;

  localparam logic [7:0] COLOR_THRESH_DEFAULT = 8'd64;

  // ID bits per LED; the display side sizes its address word with the same function
  function automatic int unsigned led_addr_width(input int unsigned num_leds);
    return $clog2(num_leds);
  endfunction

  // Red/blue decision on 9-bit sums so b+thresh cannot wrap
  function automatic pix_class_t classify(input logic [7:0] r_in,
                                          input logic [7:0] b_in,
                                          input logic [7:0] thresh);
    logic [8:0] r9;
    logic [8:0] b9;
    logic [8:0] t9;
    r9 = 9'(r_in);
    b9 = 9'(b_in);
    t9 = 9'(thresh);
    if (r9 >= b9 + t9) return CLS_RED;
    if (b9 >= r9 + t9) return CLS_BLUE;
    return CLS_NONE;
  endfunction

endpackage

// File: rtl/xilinx_true_dual_port_read_first_1_clock_ram.sv
// Single-clock dual-port block RAM, 2-cycle read latency.
//   clk, rst      - clock; rst clears the read pipeline (not the array)
//   addra/douta   - port A read
//   addrb/dinb/web- port B write
module xilinx_true_dual_port_read_first_1_clock_ram #(
  parameter int unsigned RAM_WIDTH  = 8,
  parameter int unsigned RAM_DEPTH  = 16,
  parameter int unsigned ADDR_WIDTH = $clog2(RAM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addra,
  output logic [RAM_WIDTH-1:0]  douta,
  input  logic [ADDR_WIDTH-1:0] addrb,
  input  logic [RAM_WIDTH-1:0]  dinb,
  input  logic                  web
);

  logic [RAM_WIDTH-1:0] r_mem [RAM_DEPTH];
  logic [RAM_WIDTH-1:0] r_a_pipe;
  logic [RAM_WIDTH-1:0] r_douta;

  // Write port
  always_ff @(posedge clk) begin
    if (web) r_mem[addrb] <= dinb;
  end

  // Read port: array read register then output register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_pipe <= '0;
      r_douta  <= '0;
    end else begin
      r_a_pipe <= r_mem[addra];
      r_douta  <= r_a_pipe;
    end
  end

  assign douta = r_douta;

endmodule

// File: rtl/calib_id_decoder.sv
// Steps the LED display through each ID bit (MSB first), captures one frame
// per bit and accumulates {known, id} per camera pixel in block RAM.
//   clk, rst (sync, active-high), start
//   pixel_valid, frame_start, hcount, vcount, r, g, b   - camera stream
//   update_address_bit_num, address_bit_num_req, displayed_frame_valid - display
//   rd_req, rd_addr, rd_valid, rd_data                  - solver readout
//   busy, done, glitch, current_bit                     - status
module calib_id_decoder
  import calib_pkg::*;
#(
  parameter int unsigned NUM_LEDS          = 50,
  parameter int unsigned LED_ADDRESS_WIDTH = led_addr_width(NUM_LEDS),
  parameter int unsigned BIT_NUM_WIDTH     = $clog2(LED_ADDRESS_WIDTH),
  parameter int unsigned H_PIXELS          = 320,
  parameter int unsigned V_PIXELS          = 180,
  parameter int unsigned SETTLE_FRAMES     = 2,
  parameter logic [7:0]  COLOR_THRESH      = COLOR_THRESH_DEFAULT
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic                                  pixel_valid,
  input  logic                                  frame_start,
  input  logic [$clog2(H_PIXELS)-1:0]           hcount,
  input  logic [$clog2(V_PIXELS)-1:0]           vcount,
  input  logic [7:0]                            r,
  input  logic [7:0]                            g,
  input  logic [7:0]                            b,
  output logic                                  update_address_bit_num,
  output logic [BIT_NUM_WIDTH-1:0]              address_bit_num_req,
  input  logic                                  displayed_frame_valid,
  input  logic                                  rd_req,
  input  logic [$clog2(H_PIXELS*V_PIXELS)-1:0]  rd_addr,
  output logic                                  rd_valid,
  output logic [LED_ADDRESS_WIDTH:0]            rd_data,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  glitch,
  output logic [BIT_NUM_WIDTH-1:0]              current_bit
);

  localparam int unsigned W     = LED_ADDRESS_WIDTH;
  localparam int unsigned BW    = BIT_NUM_WIDTH;
  localparam int unsigned HW    = $clog2(H_PIXELS);
  localparam int unsigned VW    = $clog2(V_PIXELS);
  localparam int unsigned DEPTH = H_PIXELS * V_PIXELS;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned DW    = W + 1;
  localparam int unsigned FW    = (SETTLE_FRAMES > 0) ? $clog2(SETTLE_FRAMES + 1) : 1;

  state_t         r_state, w_state_nxt;
  logic [BW-1:0]  r_k, w_k_nxt;
  logic           r_glitch, w_glitch_nxt;
  logic [FW-1:0]  r_frame_cnt, w_frame_cnt_nxt;
  logic           r_wv_seen, w_wv_seen_nxt;
  logic [1:0]     r_drain_cnt, w_drain_cnt_nxt;
  logic           r_update, r_busy, r_done;
  logic           w_cap, w_last;

  // Green carries no information for red/blue classification
  logic w_unused_g;
  assign w_unused_g = ^g;

  assign w_last = (hcount == HW'(H_PIXELS - 1)) && (vcount == VW'(V_PIXELS - 1));

  // State register and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_k         <= '0;
      r_glitch    <= 1'b0;
      r_frame_cnt <= '0;
      r_wv_seen   <= 1'b0;
      r_drain_cnt <= '0;
      r_update    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_k         <= w_k_nxt;
      r_glitch    <= w_glitch_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
      r_wv_seen   <= w_wv_seen_nxt;
      r_drain_cnt <= w_drain_cnt_nxt;
      r_update    <= (w_state_nxt == ST_REQ);
      r_busy      <= (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_DONE);
      r_done      <= (w_state_nxt == ST_DONE);
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt     = r_state;
    w_k_nxt         = r_k;
    w_glitch_nxt    = r_glitch;
    w_frame_cnt_nxt = r_frame_cnt;
    w_wv_seen_nxt   = r_wv_seen;
    w_drain_cnt_nxt = r_drain_cnt;
    w_cap           = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_k_nxt      = '0;
          w_glitch_nxt = 1'b0;
          w_state_nxt  = ST_REQ;
        end
      end
      ST_REQ: begin
        w_wv_seen_nxt = 1'b0;
        w_state_nxt   = ST_WAIT_VALID;
      end
      ST_WAIT_VALID: begin
        // First cycle's valid still reflects the previous bit
        if (!r_wv_seen) begin
          w_wv_seen_nxt = 1'b1;
        end else if (displayed_frame_valid) begin
          w_frame_cnt_nxt = '0;
          w_state_nxt     = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (!displayed_frame_valid) begin
          w_wv_seen_nxt = 1'b0;
          w_state_nxt   = ST_WAIT_VALID;
        end else if (pixel_valid && frame_start) begin
          if (r_frame_cnt == FW'(SETTLE_FRAMES)) begin
            w_cap       = 1'b1;
            w_state_nxt = w_last ? ST_DRAIN : ST_CAPTURE;
            w_drain_cnt_nxt = '0;
          end else begin
            w_frame_cnt_nxt = r_frame_cnt + 1'b1;
          end
        end
      end
      ST_CAPTURE: begin
        if (!displayed_frame_valid) w_glitch_nxt = 1'b1;
        if (pixel_valid) begin
          w_cap = 1'b1;
          if (w_last) begin
            w_drain_cnt_nxt = '0;
            w_state_nxt     = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // Three cycles covers input register plus RAM read latency
        if (r_drain_cnt == 2'd2) begin
          if (r_k == BW'(W - 1)) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_k_nxt     = r_k + 1'b1;
            w_state_nxt = ST_REQ;
          end
        end else begin
          w_drain_cnt_nxt = r_drain_cnt + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Capture pipeline: s1 issues the RMW read, s3 meets the read data and writes
  pix_class_t    w_cls;
  logic [AW-1:0] w_addr;
  logic          r_s1_valid, r_s2_valid, r_s3_valid;
  logic [AW-1:0] r_s1_addr, r_s2_addr, r_s3_addr;
  logic          r_s1_known, r_s2_known, r_s3_known;
  logic          r_s1_bit, r_s2_bit, r_s3_bit;
  logic          r_s1_first, r_s2_first, r_s3_first;

  assign w_cls  = classify(r, b, COLOR_THRESH);
  assign w_addr = AW'(vcount) * AW'(H_PIXELS) + AW'(hcount);

  always_ff @(posedge clk) begin
    r_s1_addr  <= w_addr;
    r_s1_known <= (w_cls != CLS_NONE);
    r_s1_bit   <= (w_cls == CLS_BLUE);
    r_s1_first <= (r_k == '0);
    r_s2_addr  <= r_s1_addr;
    r_s2_known <= r_s1_known;
    r_s2_bit   <= r_s1_bit;
    r_s2_first <= r_s1_first;
    r_s3_addr  <= r_s2_addr;
    r_s3_known <= r_s2_known;
    r_s3_bit   <= r_s2_bit;
    r_s3_first <= r_s2_first;
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s3_valid <= 1'b0;
    end else begin
      r_s1_valid <= w_cap;
      r_s2_valid <= r_s1_valid;
      r_s3_valid <= r_s2_valid;
    end
  end

  // Readout pipeline, accepted only while idle
  logic r_rd_v1, r_rd_v2;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_v1 <= 1'b0;
      r_rd_v2 <= 1'b0;
    end else begin
      r_rd_v1 <= rd_req && !r_busy;
      r_rd_v2 <= r_rd_v1;
    end
  end

  logic [AW-1:0] w_addra;
  logic [DW-1:0] w_douta;
  logic [DW-1:0] w_wdata;

  // Pixel reads only occur while busy, so they never collide with readout
  assign w_addra = r_s1_valid ? r_s1_addr : rd_addr;

  // Bit 0 pass overwrites the word; later passes shift the new bit in at the LSB
  always_comb begin
    if (r_s3_first) w_wdata = {r_s3_known, W'(r_s3_bit)};
    else            w_wdata = {w_douta[W] & r_s3_known, w_douta[W-2:0], r_s3_bit};
  end

  xilinx_true_dual_port_read_first_1_clock_ram #(
    .RAM_WIDTH (DW),
    .RAM_DEPTH (DEPTH),
    .ADDR_WIDTH(AW)
  ) u_id_ram (
    .clk  (clk),
    .rst  (rst),
    .addra(w_addra),
    .douta(w_douta),
    .addrb(r_s3_addr),
    .dinb (w_wdata),
    .web  (r_s3_valid)
  );

  assign update_address_bit_num = r_update;
  assign address_bit_num_req    = r_k;
  assign current_bit            = r_k;
  assign busy                   = r_busy;
  assign done                   = r_done;
  assign glitch                 = r_glitch;
  assign rd_valid               = r_rd_v2;
  assign rd_data                = w_douta;

endmodule

// File: tb/tb_calib_id_decoder.sv
// Directed bench for calib_id_decoder on a 4x2 frame with a small display model.
module tb_calib_id_decoder;
  import calib_pkg::*;

  localparam int unsigned HW = 2;
  localparam int unsigned VW = 1;
  localparam int unsigned AW = 3;
  localparam int unsigned BW = 3;
  localparam int unsigned W  = 6;

  logic          clk = 1'b0;
  logic          rst, start, pixel_valid, frame_start;
  logic [HW-1:0] hcount;
  logic [VW-1:0] vcount;
  logic [7:0]    r, g, b;
  logic          update_address_bit_num;
  logic [BW-1:0] address_bit_num_req;
  logic          displayed_frame_valid;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_valid;
  logic [W:0]    rd_data;
  logic          busy, done, glitch;
  logic [BW-1:0] current_bit;

  always #5 clk = ~clk;

  calib_id_decoder #(
    .NUM_LEDS(50), .H_PIXELS(4), .V_PIXELS(2), .SETTLE_FRAMES(1), .COLOR_THRESH(8'd64)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pixel_valid(pixel_valid),
    .frame_start(frame_start), .hcount(hcount), .vcount(vcount),
    .r(r), .g(g), .b(b),
    .update_address_bit_num(update_address_bit_num),
    .address_bit_num_req(address_bit_num_req),
    .displayed_frame_valid(displayed_frame_valid),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .busy(busy), .done(done), .glitch(glitch), .current_bit(current_bit)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Hand-computed {known, id} per address (v*4+h)
  int exp_word [8] = '{1, 86, 64, 64, 0, 64, 8, 96};

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Colour shown by the LED under pixel (h,v) while bit k is displayed
  function automatic void pix_color(input int k, input int h, input int v,
                                    output logic [7:0] rr, output logic [7:0] bb);
    rr = 8'd200;
    bb = 8'd0;
    case (v * 4 + h)
      0: if (k == 2) begin rr = 8'd200; bb = 8'd255; end
         else if (k == 5) begin rr = 8'd0; bb = 8'd255; end
      1: if (k == 1 || k == 3 || k == 4) begin rr = 8'd0; bb = 8'd200; end
      3: begin rr = 8'd164; bb = 8'd100; end
      4: if (k == 5) begin rr = 8'd100; bb = 8'd163; end
      6: if (k == 2) begin rr = 8'd0; bb = 8'd200; end
         else if (k == 3) begin rr = 8'd100; bb = 8'd100; end
      7: if (k == 0) begin rr = 8'd191; bb = 8'd255; end
      default: ;
    endcase
  endfunction

  // Display model + continuous camera stream (8 pixels, 2 blank cycles)
  int   shown_bit = 0;
  int   vdly = 0;
  logic hold_invalid = 1'b0;
  logic drop_valid = 1'b0;

  initial begin
    logic [7:0] rr, bb;
    pixel_valid = 1'b0; frame_start = 1'b0; hcount = '0; vcount = '0;
    r = '0; g = '0; b = '0; displayed_frame_valid = 1'b0;
    forever begin
      for (int slot = 0; slot < 10; slot++) begin
        @(posedge clk); #1;
        if (update_address_bit_num) begin
          shown_bit = int'(address_bit_num_req);
          vdly = 0;
        end else if (vdly < 4) begin
          vdly++;
        end
        displayed_frame_valid = (vdly >= 4) && !hold_invalid && !drop_valid;
        if (slot < 8) begin
          pixel_valid = 1'b1;
          frame_start = (slot == 0);
          hcount = HW'(slot % 4);
          vcount = VW'(slot / 4);
          pix_color(shown_bit, slot % 4, slot / 4, rr, bb);
          r = rr; b = bb; g = 8'(slot * 37);
        end else begin
          pixel_valid = 1'b0;
          frame_start = (slot == 8);
          r = '0; b = '0;
        end
      end
    end
  end

  // Event monitor: request pulses, RAM writes, done-vs-last-write timing
  int            pulse_cnt = 0;
  int            wr_cnt = 0;
  logic [BW-1:0] last_req = '0;
  logic          prev_we = 1'b0;
  logic          prev_done = 1'b0;

  always @(posedge clk) begin
    if (done && !prev_done)
      check_eq("done_after_last_write", int'(prev_we) * 2 + int'(dut.r_s3_valid), 2);
    prev_we   = dut.r_s3_valid;
    prev_done = done;
    if (update_address_bit_num) begin
      pulse_cnt++;
      last_req = address_bit_num_req;
    end
    if (dut.r_s3_valid) wr_cnt++;
  end

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, ".update"}, int'(update_address_bit_num), 0);
    check_eq({tag, ".req"}, int'(address_bit_num_req), 0);
    check_eq({tag, ".rd_valid"}, int'(rd_valid), 0);
    check_eq({tag, ".rd_data"}, int'(rd_data), 0);
    check_eq({tag, ".busy"}, int'(busy), 0);
    check_eq({tag, ".done"}, int'(done), 0);
    check_eq({tag, ".glitch"}, int'(glitch), 0);
    check_eq({tag, ".current_bit"}, int'(current_bit), 0);
    check_eq({tag, ".state"}, int'(dut.r_state), int'(ST_IDLE));
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 5000) begin @(negedge clk); n++; end
    check_eq({tag, ".done_reached"}, int'(n < 5000), 1);
  endtask

  task automatic wait_capture(input int k, input string tag);
    int n = 0;
    while (!(dut.r_state == ST_CAPTURE && current_bit == BW'(k)) && n < 5000) begin
      @(negedge clk); n++;
    end
    check_eq({tag, ".capture_reached"}, int'(n < 5000), 1);
  endtask

  task automatic read_check(input int a, input string tag);
    @(negedge clk); rd_req = 1'b1; rd_addr = AW'(a);
    @(negedge clk); rd_req = 1'b0;
    @(negedge clk);
    check_eq($sformatf("%s.rd_valid[%0d]", tag, a), int'(rd_valid), 1);
    check_eq($sformatf("%s.rd_data[%0d]", tag, a), int'(rd_data), exp_word[a]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rv;
    int n;
    rst = 1'b1; start = 1'b0; rd_req = 1'b0; rd_addr = '0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;

    // Display never becomes valid: one request, then stuck in WAIT_VALID
    hold_invalid = 1'b1;
    pulse_start();
    check_eq("start.busy", int'(busy), 1);
    check_eq("start.update", int'(update_address_bit_num), 1);
    check_eq("start.req", int'(address_bit_num_req), 0);
    rv = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rd_valid) rv++;
      rd_req = (i == 10);
      rd_addr = AW'(1);
    end
    rd_req = 1'b0;
    check_eq("rd_while_busy.rd_valid", rv, 0);
    check_eq("hold.state", int'(dut.r_state), int'(ST_WAIT_VALID));
    check_eq("hold.writes", wr_cnt, 0);
    check_eq("hold.pulses", pulse_cnt, 1);

    // Release, then a one-cycle valid drop in SETTLE
    hold_invalid = 1'b0;
    n = 0;
    while (dut.r_state != ST_SETTLE && n < 500) begin @(negedge clk); n++; end
    check_eq("settle_reached", int'(n < 500), 1);
    drop_valid = 1'b1;
    @(negedge clk); drop_valid = 1'b0;
    @(negedge clk);
    check_eq("settle_drop.state", int'(dut.r_state), int'(ST_WAIT_VALID));
    wait_done("run1");
    check_eq("run1.pulses", pulse_cnt, 6);
    check_eq("run1.last_req", int'(last_req), 5);
    check_eq("run1.writes", wr_cnt, 48);
    check_eq("run1.busy", int'(busy), 0);
    check_eq("run1.glitch", int'(glitch), 0);
    for (int a = 0; a < 8; a++) read_check(a, "run1");

    // Back-to-back readout of 0,1,2: data at +2,+3,+4
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i >= 2 && i <= 4) begin
        check_eq($sformatf("b2b.rd_valid[%0d]", i - 2), int'(rd_valid), 1);
        check_eq($sformatf("b2b.rd_data[%0d]", i - 2), int'(rd_data), exp_word[i - 2]);
      end
      if (i == 5) check_eq("b2b.rd_valid_after", int'(rd_valid), 0);
      rd_req = (i < 3);
      rd_addr = AW'(i);
    end
    rd_req = 1'b0;

    // Reset in the middle of capturing bit 2
    pulse_start();
    wait_capture(2, "run2");
    rst = 1'b1;
    @(negedge clk);
    check_zero_outputs("mid_reset");
    rst = 1'b0;

    // Full rerun with a valid drop during CAPTURE of bit 1
    pulse_start();
    wait_capture(1, "run3");
    drop_valid = 1'b1;
    @(negedge clk); drop_valid = 1'b0;
    wait_done("run3");
    check_eq("run3.glitch", int'(glitch), 1);
    for (int a = 0; a < 8; a++) read_check(a, "run3");

    // Start clears the sticky glitch
    pulse_start();
    check_eq("run4.glitch_cleared", int'(glitch), 0);
    check_eq("run4.current_bit", int'(current_bit), 0);
    wait_done("run4");
    check_eq("run4.glitch", int'(glitch), 0);
    read_check(1, "run4");
    read_check(6, "run4");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
